// File: rtl/lcd8080_pkg.sv
// Shared definitions for the i8080 write initiator and its receiving bridge.
package lcd8080_pkg;

   localparam int CNT_W = 4;

   // Default bus timing in clock cycles. The receiving bridge uses the same values.
   localparam int DEF_T_AS  = 1;
   localparam int DEF_T_WRL = 2;
   localparam int DEF_T_WRH = 2;
   localparam int DEF_T_CSH = 1;

   typedef logic [CNT_W-1:0] cnt_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_WRLOW,
      ST_WRHIGH,
      ST_CSHOLD
   } state_e;

   // A phase of N cycles is timed by loading N-1 and waiting for zero.
   function automatic cnt_t phase_load(input int cycles);
      return cnt_t'(cycles - 1);
   endfunction

endpackage

// File: rtl/lcd8080_timer.sv
// Loadable down-counter that times each bus phase; done flags the final cycle.
module lcd8080_timer
   import lcd8080_pkg::*;
(
   input  logic clk_i,
   input  logic rst_i,
   input  logic load_i,
   input  cnt_t load_val_i,
   output logic done_o
);

   cnt_t cnt_q, cnt_d;

   // Load wins; otherwise count down and stop at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (cnt_q != '0)
         cnt_d = cnt_q - 1'b1;
   end

   // Counter register.
   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/lcd8080_master.sv
// i8080 write initiator: turns a valid/ready word stream into CS/RS/WR/D
// write cycles with programmable setup, strobe, hold and CS-hold timing.
module lcd8080_master
   import lcd8080_pkg::*;
#(
   parameter int T_AS  = DEF_T_AS,
   parameter int T_WRL = DEF_T_WRL,
   parameter int T_WRH = DEF_T_WRH,
   parameter int T_CSH = DEF_T_CSH
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        IN_Valid,
   output logic        IN_Ready,
   input  logic        IN_RS,
   input  logic        IN_Wide,
   input  logic [15:0] IN_Data,
   output logic        J80_CS,
   output logic        J80_RS,
   output logic        J80_WR,
   output logic [7:0]  J80_D,
   output logic        Busy
);

   // Every phase lasts at least one cycle and fits the 4-bit counter.
   if (T_AS < 1 || T_AS > 15 || T_WRL < 1 || T_WRL > 15 ||
       T_WRH < 1 || T_WRH > 15 || T_CSH < 1 || T_CSH > 15) begin : g_bad_timing
      $error("lcd8080_master: timing parameters must be in 1..15");
   end

   localparam cnt_t LD_AS  = phase_load(T_AS);
   localparam cnt_t LD_WRL = phase_load(T_WRL);
   localparam cnt_t LD_WRH = phase_load(T_WRH);
   localparam cnt_t LD_CSH = phase_load(T_CSH);

   state_e     state_q, state_d;
   logic       cs_q, wr_q, rs_q;
   logic [7:0] d_q;
   logic [7:0] lo_q;      // low byte waiting for its own beat
   logic       pend_q;    // lo_q still has to be sent
   logic       ld;
   cnt_t       ld_val;
   logic       done;
   logic       rdy;
   logic       take_lo;
   logic       accept;

   lcd8080_timer u_timer (
      .clk_i      (CLK),
      .rst_i      (RST),
      .load_i     (ld),
      .load_val_i (ld_val),
      .done_o     (done)
   );

   // Next state, phase counter loads and ready; defaults first.
   always_comb begin
      state_d = state_q;
      ld      = 1'b0;
      ld_val  = '0;
      rdy     = 1'b0;
      take_lo = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            rdy = 1'b1;
            if (IN_Valid) begin
               state_d = ST_SETUP;
               ld      = 1'b1;
               ld_val  = LD_AS;
            end
         end
         ST_SETUP: if (done) begin
            state_d = ST_WRLOW;
            ld      = 1'b1;
            ld_val  = LD_WRL;
         end
         ST_WRLOW: if (done) begin
            state_d = ST_WRHIGH;
            ld      = 1'b1;
            ld_val  = LD_WRH;
         end
         ST_WRHIGH: if (done) begin
            ld = 1'b1;
            if (pend_q) begin
               // Second beat of a wide word: CS stays low, no new input taken.
               state_d = ST_SETUP;
               ld_val  = LD_AS;
               take_lo = 1'b1;
            end else begin
               rdy = 1'b1;
               if (IN_Valid) begin
                  state_d = ST_SETUP;
                  ld_val  = LD_AS;
               end else begin
                  state_d = ST_CSHOLD;
                  ld_val  = LD_CSH;
               end
            end
         end
         ST_CSHOLD: if (done) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (RST) rdy = 1'b0;
   end

   assign accept = rdy && IN_Valid;

   // State, holding regs and registered bus outputs. CS/WR are decoded from
   // the next state so they change exactly at phase boundaries. D/RS load
   // only on entry to SETUP, so they are stable through WRLOW and WRHIGH.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         cs_q    <= 1'b1;
         wr_q    <= 1'b1;
         rs_q    <= 1'b0;
         d_q     <= 8'h00;
         lo_q    <= 8'h00;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cs_q    <= (state_d == ST_IDLE);
         wr_q    <= (state_d != ST_WRLOW);
         if (accept) begin
            rs_q   <= IN_RS;
            d_q    <= IN_Wide ? IN_Data[15:8] : IN_Data[7:0];
            lo_q   <= IN_Data[7:0];
            pend_q <= IN_Wide;
         end else if (take_lo) begin
            d_q    <= lo_q;
            pend_q <= 1'b0;
         end
      end
   end

   assign IN_Ready = rdy;
   assign J80_CS   = cs_q;
   assign J80_WR   = wr_q;
   assign J80_RS   = rs_q;
   assign J80_D    = d_q;
   assign Busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lcd8080_master.sv
// Bench for lcd8080_master: cycle table for default timing plus hand
// sequences for ignored inputs, mid-transfer reset and custom timing.
module tb_lcd8080_master;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        IN_Valid = 1'b0, IN_RS = 1'b0, IN_Wide = 1'b0;
   logic [15:0] IN_Data = 16'h0000;
   logic        IN_Ready, J80_CS, J80_RS, J80_WR, Busy;
   logic [7:0]  J80_D;
   logic        V2 = 1'b0;
   logic        rdy2, cs2, rs2, wr2, busy2;
   logic [7:0]  d2;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   lcd8080_master #(.T_AS(1), .T_WRL(2), .T_WRH(2), .T_CSH(1)) dut (
      .CLK(CLK), .RST(RST), .IN_Valid(IN_Valid), .IN_Ready(IN_Ready),
      .IN_RS(IN_RS), .IN_Wide(IN_Wide), .IN_Data(IN_Data),
      .J80_CS(J80_CS), .J80_RS(J80_RS), .J80_WR(J80_WR), .J80_D(J80_D), .Busy(Busy)
   );

   lcd8080_master #(.T_AS(3), .T_WRL(4), .T_WRH(1), .T_CSH(2)) dut2 (
      .CLK(CLK), .RST(RST), .IN_Valid(V2), .IN_Ready(rdy2),
      .IN_RS(IN_RS), .IN_Wide(IN_Wide), .IN_Data(IN_Data),
      .J80_CS(cs2), .J80_RS(rs2), .J80_WR(wr2), .J80_D(d2), .Busy(busy2)
   );

   typedef struct packed {
      logic        v, rs, wide;
      logic [15:0] dat;
      logic        ecs, ewr, ers;
      logic [7:0]  ed;
      logic        ebusy, erdy;
   } vec_t;

   vec_t tbl[$];

   task automatic V(input logic v, rs, w, input logic [15:0] dat,
                    input logic ecs, ewr, ers, input logic [7:0] ed,
                    input logic eb, er);
      vec_t e;
      e = '{v, rs, w, dat, ecs, ewr, ers, ed, eb, er};
      tbl.push_back(e);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic v, rs, w, input logic [15:0] dat);
      IN_Valid = v; IN_RS = rs; IN_Wide = w; IN_Data = dat;
   endtask

   task automatic tick();
      @(posedge CLK); #1;
   endtask

   function automatic logic [12:0] outs();
      return {J80_CS, J80_WR, J80_RS, J80_D, Busy, IN_Ready};
   endfunction

   initial begin
      int wl;
      logic [7:0] seen;
      logic [15:0] wmask, cmask, bmask;

      // Cycle table, default timing. Columns: valid rs wide data | cs wr rs d busy rdy
      // Command 0x2C; junk inputs while not ready must be ignored.
      V(1,0,0,16'h002C, 1,1,0,8'h00,0,1);
      V(0,1,1,16'hFFFF, 0,1,0,8'h2C,1,0);
      V(1,1,0,16'h1234, 0,0,0,8'h2C,1,0);
      V(0,0,0,16'h0000, 0,0,0,8'h2C,1,0);
      V(1,0,1,16'hBEEF, 0,1,0,8'h2C,1,0);
      V(0,0,0,16'h0000, 0,1,0,8'h2C,1,1);
      V(1,1,1,16'h5555, 0,1,0,8'h2C,1,0);
      // Idle, accept wide pixel 0xF81F.
      V(1,1,1,16'hF81F, 1,1,0,8'h2C,0,1);
      V(0,0,0,16'h0000, 0,1,1,8'hF8,1,0);
      V(0,0,0,16'h0000, 0,0,1,8'hF8,1,0);
      V(0,0,0,16'h0000, 0,0,1,8'hF8,1,0);
      V(0,0,0,16'h0000, 0,1,1,8'hF8,1,0);
      V(0,0,0,16'h0000, 0,1,1,8'hF8,1,0);
      V(0,0,0,16'h0000, 0,1,1,8'h1F,1,0);
      V(0,0,0,16'h0000, 0,0,1,8'h1F,1,0);
      V(0,0,0,16'h0000, 0,0,1,8'h1F,1,0);
      V(0,0,0,16'h0000, 0,1,1,8'h1F,1,0);
      // Last WRHIGH of pixel: accept 0x2C directly, no CS hold.
      V(1,0,0,16'h002C, 0,1,1,8'h1F,1,1);
      V(1,1,0,16'h0012, 0,1,0,8'h2C,1,0);
      V(1,1,0,16'h0012, 0,0,0,8'h2C,1,0);
      V(1,1,0,16'h0012, 0,0,0,8'h2C,1,0);
      V(1,1,0,16'h0012, 0,1,0,8'h2C,1,0);
      V(1,1,0,16'h0012, 0,1,0,8'h2C,1,1);
      V(1,1,0,16'h0034, 0,1,1,8'h12,1,0);
      V(1,1,0,16'h0034, 0,0,1,8'h12,1,0);
      V(1,1,0,16'h0034, 0,0,1,8'h12,1,0);
      V(1,1,0,16'h0034, 0,1,1,8'h12,1,0);
      V(1,1,0,16'h0034, 0,1,1,8'h12,1,1);
      V(0,0,0,16'h0000, 0,1,1,8'h34,1,0);
      V(0,0,0,16'h0000, 0,0,1,8'h34,1,0);
      V(0,0,0,16'h0000, 0,0,1,8'h34,1,0);
      V(0,0,0,16'h0000, 0,1,1,8'h34,1,0);
      V(0,0,0,16'h0000, 0,1,1,8'h34,1,1);
      V(0,0,0,16'h0000, 0,1,1,8'h34,1,0);
      V(0,0,0,16'h0000, 1,1,1,8'h34,0,1);

      // Reset: ready low while RST, registered outputs at reset values.
      tick();
      @(negedge CLK); chk("rdy_in_rst", IN_Ready, 0);
      tick();
      @(negedge CLK); chk("rst_vals", outs(), {1'b1,1'b1,1'b0,8'h00,1'b0,1'b0});
      chk("rst_vals2", {cs2, wr2, busy2, rdy2}, 4'b1100);
      tick();
      RST = 1'b0;

      foreach (tbl[i]) begin
         drive(tbl[i].v, tbl[i].rs, tbl[i].wide, tbl[i].dat);
         @(negedge CLK);
         chk($sformatf("vec%0d", i), outs(),
             {tbl[i].ecs, tbl[i].ewr, tbl[i].ers, tbl[i].ed, tbl[i].ebusy, tbl[i].erdy});
         tick();
      end

      // Valid toggling with changing data while not ready: one pulse, 0x55 only.
      drive(1, 0, 0, 16'h0055);
      @(negedge CLK); tick();
      wl = 0;
      for (int k = 1; k <= 6; k++) begin
         drive((k < 5) ? k[0] : 1'b0, $urandom_range(0, 1), $urandom_range(0, 1),
               16'($urandom));
         @(negedge CLK);
         if (!J80_WR) wl++;
         chk($sformatf("tog_d%0d", k), {J80_RS, J80_D}, {1'b0, 8'h55});
         tick();
      end
      drive(0, 0, 0, 16'h0000);
      @(negedge CLK);
      chk("tog_wrlow_cycles", wl, 2);
      chk("tog_idle", {J80_CS, Busy}, 2'b10);
      tick();

      // Reset during WRLOW, then a fresh word goes out complete.
      drive(1, 1, 0, 16'h00A5);
      @(negedge CLK); tick();
      drive(0, 0, 0, 16'h0000);
      tick();
      @(negedge CLK);
      chk("pre_rst_wrlow", {J80_WR, J80_D}, {1'b0, 8'hA5});
      RST = 1'b1;
      #1 chk("rdy_mid_rst", IN_Ready, 0);
      tick();
      RST = 1'b0;
      @(negedge CLK);
      chk("mid_rst_vals", outs(), {1'b1,1'b1,1'b0,8'h00,1'b0,1'b1});
      tick();
      wl = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         if (!J80_WR || !J80_CS) wl++;
         tick();
      end
      chk("no_resend", wl, 0);
      drive(1, 0, 0, 16'h003C);
      @(negedge CLK); tick();
      drive(0, 0, 0, 16'h0000);
      wl = 0; seen = 8'h00;
      for (int k = 1; k <= 7; k++) begin
         @(negedge CLK);
         if (!J80_WR) begin wl++; seen = J80_D; end
         tick();
      end
      chk("post_rst_wrlow_cycles", wl, 2);
      chk("post_rst_data", seen, 8'h3C);
      @(negedge CLK);
      chk("post_rst_idle", {J80_CS, Busy}, 2'b10);

      // Custom timing 3/4/1/2: WR low 4..7, CS low 1..10, idle at 11.
      tick();
      V2 = 1'b1; drive(0, 1, 0, 16'h0081);
      wmask = '0; cmask = '0; bmask = '0;
      for (int c = 0; c <= 12; c++) begin
         @(negedge CLK);
         wmask[c] = ~wr2; cmask[c] = ~cs2; bmask[c] = busy2;
         if (c == 5) chk("t2_data", {rs2, d2}, {1'b1, 8'h81});
         if (c == 0) chk("t2_rdy", rdy2, 1);
         tick();
         V2 = 1'b0;
      end
      chk("t2_wr_low", wmask, 16'h00F0);
      chk("t2_cs_low", cmask, 16'h07FE);
      chk("t2_busy", bmask, 16'h07FE);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
